// File: rtl/render_pkg.sv
// Shared constants and helpers for the tile raster renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package render_pkg;

    // Default 640x480@60 raster timing; the modules expose these as parameters.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Tile codes held in the mini-map RAM.
    localparam logic [3:0] TILE_EMPTY        = 4'd0;
    localparam logic [3:0] TILE_WALL         = 4'd1;
    localparam logic [3:0] TILE_PELLET       = 4'd2;
    localparam logic [3:0] TILE_POWER        = 4'd3;
    localparam logic [3:0] TILE_PAC          = 4'd4;
    localparam logic [3:0] TILE_GHOST_ORANGE = 4'd5;
    localparam logic [3:0] TILE_GHOST_CYAN   = 4'd6;
    localparam logic [3:0] TILE_GHOST_RED    = 4'd7;
    localparam logic [3:0] TILE_GHOST_PINK   = 4'd8;

    localparam logic [2:0] WALL_CELL = 3'b001;

    // 4x4 sprite masks, bit s = cell y*4+x within the 16x16 tile.
    localparam logic [15:0] PELLET_MASK = 16'h0020;  // {5}
    localparam logic [15:0] POWER_MASK  = 16'h0660;  // {5,6,9,10}
    localparam logic [15:0] PAC_IDLE    = 16'h6FF6;  // all but corners {0,3,12,15}
    localparam logic [15:0] PAC_RIGHT   = 16'h6776;  // idle minus {7,11}
    localparam logic [15:0] PAC_LEFT    = 16'h6EE6;  // idle minus {4,8}
    localparam logic [15:0] PAC_UP      = 16'h6FF0;  // idle minus {1,2}
    localparam logic [15:0] PAC_DOWN    = 16'h0FF6;  // idle minus {13,14}

    // Ghost sprite, 2 bits per cell at [2s+1:2s]: 0 empty, 1 body, 2 eye.
    localparam logic [31:0] GHOST_MAP = 32'h4196_5514;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK  = '{8'd0,   8'd0,   8'd0};
    localparam rgb_t RGB_WHITE  = '{8'd255, 8'd255, 8'd255};
    localparam rgb_t RGB_WALL   = '{8'd0,   8'd0,   8'd250};
    localparam rgb_t RGB_YELLOW = '{8'd255, 8'd255, 8'd0};

    function automatic logic [15:0] pac_mask(input logic [2:0] frame);
        case (frame)
            3'd1:    pac_mask = PAC_RIGHT;
            3'd2:    pac_mask = PAC_LEFT;
            3'd3:    pac_mask = PAC_UP;
            3'd4:    pac_mask = PAC_DOWN;
            default: pac_mask = PAC_IDLE;
        endcase
    endfunction

    // Body colour for each ghost tile code.
    function automatic rgb_t ghost_body(input logic [3:0] tile);
        case (tile)
            TILE_GHOST_ORANGE: ghost_body = '{8'd255, 8'd128, 8'd0};
            TILE_GHOST_CYAN:   ghost_body = '{8'd0,   8'd255, 8'd255};
            TILE_GHOST_RED:    ghost_body = '{8'd255, 8'd0,   8'd0};
            TILE_GHOST_PINK:   ghost_body = '{8'd255, 8'd190, 8'd200};
            default:           ghost_body = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/tile_raster_renderer_if.sv
// Bundle between the renderer, the game-state RAMs and the VGA pad driver.
// Latency: n/a (wires only); RAM data is expected one cycle after its address.
// Backpressure: none; master = renderer, slave = RAMs / pad driver side.
interface tile_raster_renderer_if;
    logic [10:0] map_addr;      // mini-map read address
    logic [3:0]  map_data;      // tile code, 1-cycle RAM latency
    logic [14:0] wall_addr;     // maze bitmap read address
    logic [2:0]  wall_data;     // maze cell, 1-cycle RAM latency
    logic [2:0]  pac_frame;     // pac-man sprite select
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync_n;
    logic        vsync_n;
    logic        blank_n;
    logic        vblank_start;  // game-update strobe, straight from the counters

    modport master (
        output map_addr, wall_addr, red, green, blue,
               hsync_n, vsync_n, blank_n, vblank_start,
        input  map_data, wall_data, pac_frame
    );

    modport slave (
        input  map_addr, wall_addr, red, green, blue,
               hsync_n, vsync_n, blank_n, vblank_start,
        output map_data, wall_data, pac_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with sync, active and vblank_start decode.
// Latency: decodes are combinational from the counter registers.
// Backpressure: none, free-running whenever reset is high.
// Ports: VGA_CLK, reset (sync, active-low); cell_x/cell_y = h>>2 / v>>2,
//        active, hs_n, vs_n, vblank_start for the current counter position.
module vga_timing_gen import render_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       VGA_CLK,
    input  logic       reset,
    output logic [7:0] cell_x,
    output logic [7:0] cell_y,
    output logic       active,
    output logic       hs_n,
    output logic       vs_n,
    output logic       vblank_start
);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h;
    logic [9:0] v;

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign cell_x       = h[9:2];
    assign cell_y       = v[9:2];
    assign active       = (h < H_VIS) && (v < V_VIS);
    assign hs_n         = !((h >= HS_START) && (h < HS_END));
    assign vs_n         = !((v >= VS_START) && (v < VS_END));
    assign vblank_start = (h == 10'd0) && (v == V_VIS);
endmodule

// File: rtl/tile_raster_renderer.sv
// Renders the 40x30 tile map through 4x4 sprite bitmaps into registered RGB + syncs.
// Latency: 3 cycles counter->RGB/sync/blank; vblank_start is undelayed.
// Backpressure: none; RAMs must answer one cycle after each address.
// Ports: VGA_CLK, reset (sync, active-low), bus (master modport): RAM addresses
//        out / data in, pac_frame in, RGB, hsync_n, vsync_n, blank_n, vblank_start out.
module tile_raster_renderer import render_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                   VGA_CLK,
    input  logic                   reset,
    tile_raster_renderer_if.master bus
);
    logic [7:0] cell_x;
    logic [7:0] cell_y;
    logic       tg_active;
    logic       tg_hs_n;
    logic       tg_vs_n;
    logic       tg_vblank;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .VGA_CLK      (VGA_CLK),
        .reset        (reset),
        .cell_x       (cell_x),
        .cell_y       (cell_y),
        .active       (tg_active),
        .hs_n         (tg_hs_n),
        .vs_n         (tg_vs_n),
        .vblank_start (tg_vblank)
    );

    // S1: addresses out to the RAMs, plus the sideband that must travel with them.
    logic [10:0] map_addr_q;
    logic [14:0] wall_addr_q;
    logic [1:0]  s1_sx, s1_sy;
    logic        s1_act, s1_hs_n, s1_vs_n;
    // S2: aligned with the RAM data.
    logic [1:0]  s2_sx, s2_sy;
    logic        s2_act, s2_hs_n, s2_vs_n;
    // Output stage.
    rgb_t        rgb_q;
    logic        hs_n_q, vs_n_q, blank_n_q;
    logic [2:0]  pac_lat;

    rgb_t        pix;
    logic [3:0]  s_idx;
    logic [1:0]  ghost_cell;
    logic [15:0] pac_m;

    always_comb begin
        s_idx      = {s2_sy, s2_sx};
        ghost_cell = GHOST_MAP[{s_idx, 1'b0} +: 2];
        pac_m      = pac_mask(pac_lat);
        pix        = RGB_BLACK;
        case (bus.map_data)
            TILE_PELLET: if (PELLET_MASK[s_idx]) pix = RGB_WHITE;
            TILE_POWER:  if (POWER_MASK[s_idx])  pix = RGB_WHITE;
            TILE_PAC:    if (pac_m[s_idx])       pix = RGB_YELLOW;
            TILE_GHOST_ORANGE, TILE_GHOST_CYAN, TILE_GHOST_RED, TILE_GHOST_PINK: begin
                if (ghost_cell == 2'd2)      pix = RGB_WHITE;
                else if (ghost_cell == 2'd1) pix = ghost_body(bus.map_data);
            end
            // Empty, wall and unassigned codes all fall back to the maze bitmap.
            default:     if (bus.wall_data == WALL_CELL) pix = RGB_WALL;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            map_addr_q  <= '0;
            wall_addr_q <= '0;
            s1_sx       <= '0;
            s1_sy       <= '0;
            s1_act      <= 1'b0;
            s1_hs_n     <= 1'b1;
            s1_vs_n     <= 1'b1;
            s2_sx       <= '0;
            s2_sy       <= '0;
            s2_act      <= 1'b0;
            s2_hs_n     <= 1'b1;
            s2_vs_n     <= 1'b1;
            rgb_q       <= RGB_BLACK;
            hs_n_q      <= 1'b1;
            vs_n_q      <= 1'b1;
            blank_n_q   <= 1'b0;
            pac_lat     <= '0;
        end else begin
            // Addresses hold through blanking so the RAMs see no spurious reads.
            if (tg_active) begin
                map_addr_q  <= 11'(cell_y[7:2]) * 11'd40 + 11'(cell_x[7:2]);
                wall_addr_q <= 15'(cell_y) * 15'd160 + 15'(cell_x);
            end
            s1_sx   <= cell_x[1:0];
            s1_sy   <= cell_y[1:0];
            s1_act  <= tg_active;
            s1_hs_n <= tg_hs_n;
            s1_vs_n <= tg_vs_n;

            s2_sx   <= s1_sx;
            s2_sy   <= s1_sy;
            s2_act  <= s1_act;
            s2_hs_n <= s1_hs_n;
            s2_vs_n <= s1_vs_n;

            rgb_q     <= s2_act ? pix : RGB_BLACK;
            hs_n_q    <= s2_hs_n;
            vs_n_q    <= s2_vs_n;
            blank_n_q <= s2_act;

            // Sample the sprite select once per frame so pac-man never tears.
            if (tg_vblank) pac_lat <= bus.pac_frame;
        end
    end

    assign bus.map_addr     = map_addr_q;
    assign bus.wall_addr    = wall_addr_q;
    assign bus.red          = rgb_q.r;
    assign bus.green        = rgb_q.g;
    assign bus.blue         = rgb_q.b;
    assign bus.hsync_n      = hs_n_q;
    assign bus.vsync_n      = vs_n_q;
    assign bus.blank_n      = blank_n_q;
    assign bus.vblank_start = tg_vblank;
endmodule

// File: tb/tb_tile_raster_renderer.sv
// Bench for tile_raster_renderer with a shortened vertical frame to keep runs short.
module tb_tile_raster_renderer;
    localparam int VA    = 32;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VT    = VA + VF + VS + VB;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    logic VGA_CLK = 1'b0;
    logic reset   = 1'b0;
    always #20 VGA_CLK = ~VGA_CLK;

    tile_raster_renderer_if bus();

    tile_raster_renderer #(
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .bus     (bus)
    );

    logic [3:0]  map_mem  [0:2047];
    logic [2:0]  wall_mem [0:32767];
    logic [23:0] cap      [0:VA-1][0:639];

    // Registered RAMs: data follows the address by one cycle.
    always @(posedge VGA_CLK) begin
        bus.map_data  <= map_mem[bus.map_addr];
        bus.wall_data <= wall_mem[bus.wall_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int out_rgb();
        return int'({bus.red, bus.green, bus.blue});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},       out_rgb(),                 0);
        check({tag, "_hsync_n"},   int'(bus.hsync_n),         1);
        check({tag, "_vsync_n"},   int'(bus.vsync_n),         1);
        check({tag, "_blank_n"},   int'(bus.blank_n),         0);
        check({tag, "_vblank"},    int'(bus.vblank_start),    0);
        check({tag, "_map_addr"},  int'(bus.map_addr),        0);
        check({tag, "_wall_addr"}, int'(bus.wall_addr),       0);
    endtask

    // Reference pixel colour from the tile rules, for a visible pixel.
    function automatic int ref_pixel(input int x, input int y, input int pacf);
        int  tile, wall, s;
        bit  mouth;
        tile = int'(map_mem[(y / 16) * 40 + x / 16]);
        wall = int'(wall_mem[(y / 4) * 160 + x / 4]);
        s    = ((y % 16) / 4) * 4 + (x % 16) / 4;
        case (tile)
            2: return (s == 5) ? 'hFFFFFF : 0;
            3: return (s == 5 || s == 6 || s == 9 || s == 10) ? 'hFFFFFF : 0;
            4: begin
                if (s == 0 || s == 3 || s == 12 || s == 15) return 0;
                case (pacf)
                    1:       mouth = (s == 7  || s == 11);
                    2:       mouth = (s == 4  || s == 8);
                    3:       mouth = (s == 1  || s == 2);
                    4:       mouth = (s == 13 || s == 14);
                    default: mouth = 1'b0;
                endcase
                return mouth ? 0 : 'hFFFF00;
            end
            5, 6, 7, 8: begin
                if (s == 8 || s == 11) return 'hFFFFFF;
                if (s == 0 || s == 3 || s == 13 || s == 14) return 0;
                case (tile)
                    5:       return 'hFF8000;
                    6:       return 'h00FFFF;
                    7:       return 'hFF0000;
                    default: return 'hFFBEC8;
                endcase
            end
            default: return (wall == 1) ? 'h0000FA : 0;
        endcase
    endfunction

    // Runs ncyc cycles starting with the first cycle after reset release,
    // checking every output against the counter model each cycle.
    task automatic run_from_release(input int ncyc, input bit first_pass);
        int k, hh, vv, exp_map, exp_wall, exp_rgb, lat_cur, lat_prev;
        int hs_low, vs_low, vb_cnt;
        bit vis, vb_now;
        lat_cur = 0; lat_prev = 0; exp_map = 0; exp_wall = 0;
        hs_low = 0; vs_low = 0; vb_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge VGA_CLK);
            if (c >= 1) begin
                k  = c - 1;
                hh = k % HT;
                vv = (k / HT) % VT;
                if (hh < 640 && vv < VA) begin
                    exp_map  = (vv / 16) * 40 + hh / 16;
                    exp_wall = (vv / 4) * 160 + hh / 4;
                end
            end
            check("map_addr",  int'(bus.map_addr),  exp_map);
            check("wall_addr", int'(bus.wall_addr), exp_wall);

            vb_now = ((c % HT) == 0) && (((c / HT) % VT) == VA);
            check("vblank_start", int'(bus.vblank_start), int'(vb_now));
            if (c < FRAME && bus.vblank_start) vb_cnt++;

            if (c < 3) begin
                check("startup_rgb",     out_rgb(),         0);
                check("startup_hsync_n", int'(bus.hsync_n), 1);
                check("startup_vsync_n", int'(bus.vsync_n), 1);
                check("startup_blank_n", int'(bus.blank_n), 0);
            end else begin
                k       = c - 3;
                hh      = k % HT;
                vv      = (k / HT) % VT;
                vis     = (hh < 640) && (vv < VA);
                exp_rgb = vis ? ref_pixel(hh, vv, lat_prev) : 0;
                check("rgb",     out_rgb(),         exp_rgb);
                check("hsync_n", int'(bus.hsync_n), int'(!(hh >= 656 && hh < 752)));
                check("vsync_n", int'(bus.vsync_n), int'(!(vv >= VA + VF && vv < VA + VF + VS)));
                check("blank_n", int'(bus.blank_n), int'(vis));
                if (k < FRAME) begin
                    if (!bus.hsync_n) hs_low++;
                    if (!bus.vsync_n) vs_low++;
                end
                if (first_pass && k < FRAME && vis) cap[vv][hh] = {bus.red, bus.green, bus.blue};
                if (first_pass && k == FRAME + 4 * HT + 76) check("pac_right_mouth", out_rgb(), 0);
                if (first_pass && k == FRAME + 68)          check("pac_right_body",  out_rgb(), 'hFFFF00);
            end

            if (first_pass && c == 21 * HT + 37 + 1) begin
                check("addr_map_h37_v21",  int'(bus.map_addr),  42);
                check("addr_wall_h37_v21", int'(bus.wall_addr), 809);
            end
            if (first_pass && c == FRAME + 3) begin
                check("hsync_low_per_frame",  hs_low, 96 * VT);
                check("vsync_low_per_frame",  vs_low, 1600);
                check("vblank_pulses_frame",  vb_cnt, 1);
            end

            // Sprite select changes mid-frame; only the next vblank may pick them up.
            if (first_pass && c == 10 * HT)        bus.pac_frame = 3'd1;
            if (first_pass && c == FRAME + 5 * HT) bus.pac_frame = 3'($urandom_range(0, 7));

            lat_prev = lat_cur;
            if (vb_now) lat_cur = int'(bus.pac_frame);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int tile;
        int wall;
        int exp_rgb;
    } vec_t;

    vec_t vecs [22];

    initial begin
        vecs[0]  = '{32,  0,  7,  0, 'h000000};
        vecs[1]  = '{32,  8,  7,  0, 'hFFFFFF};
        vecs[2]  = '{36,  4,  7,  0, 'hFF0000};
        vecs[3]  = '{4,   4,  2,  0, 'hFFFFFF};
        vecs[4]  = '{0,   0,  2,  0, 'h000000};
        vecs[5]  = '{8,   4,  2,  1, 'h000000};
        vecs[6]  = '{52,  4,  3,  0, 'hFFFFFF};
        vecs[7]  = '{56,  8,  3,  0, 'hFFFFFF};
        vecs[8]  = '{48,  4,  3,  0, 'h000000};
        vecs[9]  = '{64,  0,  4,  0, 'h000000};
        vecs[10] = '{68,  0,  4,  0, 'hFFFF00};
        vecs[11] = '{76,  4,  4,  0, 'hFFFF00};
        vecs[12] = '{76,  20, 4,  0, 'hFFFF00};
        vecs[13] = '{80,  0,  0,  1, 'h0000FA};
        vecs[14] = '{84,  0,  0,  2, 'h000000};
        vecs[15] = '{96,  0,  9,  1, 'h0000FA};
        vecs[16] = '{116, 4,  5,  0, 'hFF8000};
        vecs[17] = '{132, 4,  6,  0, 'h00FFFF};
        vecs[18] = '{148, 4,  8,  0, 'hFFBEC8};
        vecs[19] = '{144, 8,  8,  0, 'hFFFFFF};
        vecs[20] = '{160, 0,  1,  1, 'h0000FA};
        vecs[21] = '{176, 0,  15, 3, 'h000000};

        for (int i = 0; i < 2048; i++)  map_mem[i]  = 4'($urandom_range(0, 15));
        for (int i = 0; i < 32768; i++) wall_mem[i] = 3'($urandom_range(0, 3));
        for (int i = 0; i < 22; i++) begin
            map_mem[(vecs[i].y / 16) * 40 + vecs[i].x / 16] = 4'(vecs[i].tile);
            wall_mem[(vecs[i].y / 4) * 160 + vecs[i].x / 4] = 3'(vecs[i].wall);
        end

        bus.pac_frame = 3'd0;
        reset         = 1'b0;
        repeat (5) @(posedge VGA_CLK);
        @(negedge VGA_CLK);
        check_reset_outputs("por");

        // Release so the first edge with reset high sees h=0.
        @(posedge VGA_CLK);
        #1 reset = 1'b1;
        // Ends in the cycle where the counters sit at h=300, v=20 of the second frame.
        run_from_release(FRAME + 20 * HT + 300 + 1, 1'b1);

        for (int i = 0; i < 22; i++)
            check($sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y),
                  int'(cap[vecs[i].y][vecs[i].x]), vecs[i].exp_rgb);

        // Mid-frame reset: everything returns to reset values on the next cycle.
        reset = 1'b0;
        @(negedge VGA_CLK);
        check_reset_outputs("midframe");
        repeat (2) @(negedge VGA_CLK);
        check_reset_outputs("midframe_hold");
        @(posedge VGA_CLK);
        #1 reset = 1'b1;
        // Latched sprite select restarts at idle regardless of pac_frame.
        run_from_release(2 * HT + 10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_raster_renderer.md
Name: tile_raster_renderer

Overview:
Produces 640x480@60 VGA raster timing and renders the 40x30 tile map (16x16 px tiles) into 24-bit RGB for the downstream vga driver. Each raster position is turned into a mini-map read address and a maze-bitmap read address. The block then decodes the returned tile code through fixed 4x4 sprite bitmaps (each sprite cell covers 4x4 px) and outputs registered RGB, with sync/blank delayed to stay aligned. It sits between the game-state RAMs (mini-map, maze bitmap) and the VGA pad driver.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch

Ports:
VGA_CLK  in  1  pixel clock (25 MHz)
reset  in  1  synchronous, active-low
map_addr  out  11  mini-map read address = tile_row*40 + tile_col
map_data  in  4  tile code; registered RAM, valid 1 cycle after map_addr
wall_addr  out  15  maze bitmap address = (y>>2)*160 + (x>>2)
wall_data  in  3  maze cell; value 3'b001 = wall; 1-cycle latency
pac_frame  in  3  pac-man sprite select: 0 idle, 1 right, 2 left, 3 up, 4 down, others idle
red, green, blue  out  8 each  pixel colour
hsync_n, vsync_n  out  1 each  active-low syncs
blank_n  out  1  high in the visible region
vblank_start  out  1  one-cycle pulse at h==0, v==V_ACTIVE (game-update strobe), not pipeline-delayed

Behaviour:
- Counters: h runs 0..799 and v runs 0..524. h wraps to 0 at 799 and increments v. v wraps to 0 at 524. Visible region: h<640 and v<480.
- Sync windows (counter stage): hsync_n low when 656<=h<752. vsync_n low when 490<=v<492.
- Pipeline, S0: counters at cycle n; map_addr and wall_addr are registered at n+1, together with delayed x[3:2], y[3:2], active, hs, vs.
- Pipeline, S1: RAM data is valid at n+2.
- Pipeline, S2: RGB, hsync_n, vsync_n and blank_n are registered at n+3. Total latency is 3 cycles, and all outputs stay mutually aligned.
- Addresses are computed only in the visible region. Outside it they hold their last value.
- Sprite index: s = y[3:2]*4 + x[3:2], using pixel-within-tile coordinates.
- Tile decode at S2. "white" means R=G=B=255; any unset colour channel is 0.
  - 0, 1, 9..15: blue=250 if wall_data==3'b001, else black.
  - 2 pellet: white if s in {5}.
  - 3 power pellet: white if s in {5,6,9,10}.
  - 4 pac-man: R=G=255 on the latched sprite mask.
  - 5..8 ghosts: ghost cell value 2 (eye) -> white. Cell value 1 (body) -> 5 orange (255,128,0), 6 cyan (0,255,255), 7 red (255,0,0), 8 pink (255,190,200). Cell value 0 -> black.
- Pac sprite mask: idle = all cells except {0,3,12,15}. The other frames remove a mouth from idle: right {7,11}, left {4,8}, up {1,2}, down {13,14}.
- pac_frame is latched only on vblank_start, so no tearing within a frame.
- Ghost map: cells {0,3,13,14}=0, {8,11}=2, all others=1.
- Blanking: when delayed active=0, RGB is forced to 0 regardless of decode.
- Reset: checked first every cycle and overrides everything, including mid-frame.
  - Outputs: h=v=0, RGB=0, hsync_n=vsync_n=1, blank_n=0, vblank_start=0, map_addr=wall_addr=0.
  - State: pipeline valid bits cleared, latched pac_frame=0.
  - After release: first visible RGB appears on cycle 3.

Decomposition:
- Package render_pkg holds the timing constants, tile-code constants (TILE_EMPTY=0 … TILE_GHOST_PINK=8), the 16-bit pellet/power/pac masks, the 32-bit ghost map and the ghost colour table.
- One natural sub-module: vga_timing_gen (h/v counters, sync/active/vblank_start generation). The renderer instantiates it and owns the pipeline and decode.

Test Plan:
- Reset held, then released at h=0 -> outputs stay at reset values through cycle 2; blank_n rises on cycle 3 with v=0.
- Run one frame -> hsync_n low for 96 of every 800 cycles; vsync_n low for exactly 1600 cycles; vblank_start pulses once per 420000 cycles.
- Counter at h=37, v=21 -> map_addr=42 and wall_addr=809 one cycle later.
- map_data=2 for tile (0,0) -> white only at x 4..7, y 4..7 on screen; everything else black, each 3 cycles after its counter position.
- Tile code 7: pixel x=32, y=0 -> black; x=32, y=8 -> white eye; x=36, y=4 -> red body. Change pac_frame mid-frame -> the pac sprite changes only after the next vblank_start.
- Assert reset at h=300, v=200 -> the next cycle shows all outputs at reset values; restart timing identical to power-up.
